// File: rtl/fill_r_pkg.sv
// rtl/fill_r_pkg.sv - shared AXI width macros, FSM encodings and response codes for fill_r
//
// Purpose : default AXI/tag widths (overridable by predefining the macros),
//           fill FSM state encodings and AXI response constants.
// Ports   : none (package).
// Options : FILL_R_CHK_EN is consumed by fill_r, not here.

`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ID
`define AXI_ID 3
`endif
`ifndef TID_WIDTH
`define TID_WIDTH 4
`endif

package fill_r_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_PUSH = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic resp_is_okay(input logic [1:0] resp);
        return resp == RESP_OKAY;
    endfunction

endpackage

// File: rtl/fill_r.sv
// rtl/fill_r.sv - cache-line fill engine: RMiss pop, single-beat R accept, response/fill-write push
//
// Purpose : pops one outstanding read-miss {tid, addr}, waits for its single
//           R beat, then pushes {tid, resp, data} to the response FIFO and,
//           for OKAY responses only, {addr, data} to the fill-write FIFO.
//           One transaction in flight; at least 3 cycles each.
// Ports   : clk, rst_n (sync, active-low)
//           rid_i/rdata_i/rresp_i/rlast_i/rvalid_i/rready_o  R channel
//           rmfifo_aempty_i/rmfifo_rden_o/rmfifo_data_i      RMiss FIFO read side
//           rspfifo_afull_i/rspfifo_wren_o/rspfifo_data_o    response FIFO write side
//           fwfifo_afull_i/fwfifo_wren_o/fwfifo_data_o       fill-write FIFO write side
//           err_o                                            sticky protocol error
// Options : define FILL_R_CHK_EN to compile in RID/RLAST checking; otherwise
//           err_o is tied low and rid_i/rlast_i are ignored.

`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ID
`define AXI_ID 3
`endif
`ifndef TID_WIDTH
`define TID_WIDTH 4
`endif

module fill_r
    import fill_r_pkg::*;
#(
    parameter int ADDR_WIDTH = `AXI_ADDR_WIDTH,
    parameter int DATA_WIDTH = `AXI_DATA_WIDTH,
    parameter int ID_WIDTH   = `AXI_ID_WIDTH,
    parameter int ID         = `AXI_ID,
    parameter int TID_WIDTH  = `TID_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [ID_WIDTH-1:0]               rid_i,
    input  logic [DATA_WIDTH-1:0]             rdata_i,
    input  logic [1:0]                        rresp_i,
    input  logic                              rlast_i,
    input  logic                              rvalid_i,
    output logic                              rready_o,
    input  logic                              rmfifo_aempty_i,
    output logic                              rmfifo_rden_o,
    input  logic [TID_WIDTH+ADDR_WIDTH-1:0]   rmfifo_data_i,
    input  logic                              rspfifo_afull_i,
    output logic                              rspfifo_wren_o,
    output logic [TID_WIDTH+2+DATA_WIDTH-1:0] rspfifo_data_o,
    input  logic                              fwfifo_afull_i,
    output logic                              fwfifo_wren_o,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0]  fwfifo_data_o,
    output logic                              err_o
);

    logic [1:0]            r_state;
    logic [TID_WIDTH-1:0]  r_tid;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;

    logic       w_okay;
    logic       w_pop;
    logic       w_accept;
    logic       w_push;
    logic [1:0] w_resp_in;

    assign w_okay   = resp_is_okay(r_resp);
    assign w_pop    = (r_state == S_IDLE) && !rmfifo_aempty_i;
    assign w_accept = (r_state == S_WAIT) && rvalid_i;
    // An error response needs only the response FIFO; the fill FIFO's
    // backpressure matters only when a line is actually written.
    assign w_push   = (r_state == S_PUSH) && !rspfifo_afull_i &&
                      (!w_okay || !fwfifo_afull_i);

    // Handshake outputs are gated by rst_n so nothing fires while reset is held.
    assign rmfifo_rden_o  = rst_n && w_pop;
    assign rready_o       = rst_n && (r_state == S_WAIT);
    assign rspfifo_wren_o = rst_n && w_push;
    assign fwfifo_wren_o  = rst_n && w_push && w_okay;

    assign rspfifo_data_o = {r_tid, r_resp, r_data};
    assign fwfifo_data_o  = {r_addr, r_data};

`ifdef FILL_R_CHK_EN
    logic w_bad_beat;
    logic r_err;

    assign w_bad_beat = (rid_i != ID[ID_WIDTH-1:0]) || !rlast_i;
    assign w_resp_in  = w_bad_beat ? RESP_SLVERR : rresp_i;
    assign err_o      = r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept && w_bad_beat) begin
            r_err <= 1'b1;
        end
    end
`else
    logic w_unused_chk;

    assign w_unused_chk = ^{rid_i, rlast_i, ID[0]};
    assign w_resp_in    = rresp_i;
    assign err_o        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_tid   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_resp  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        {r_tid, r_addr} <= rmfifo_data_i;
                        r_state         <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_accept) begin
                        r_data  <= rdata_i;
                        r_resp  <= w_resp_in;
                        r_state <= S_PUSH;
                    end
                end
                S_PUSH: begin
                    if (w_push) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fill_r.sv
// tb/tb_fill_r.sv - directed self-checking bench for fill_r

module tb_fill_r;

    localparam int AW  = `AXI_ADDR_WIDTH;
    localparam int DW  = `AXI_DATA_WIDTH;
    localparam int IW  = `AXI_ID_WIDTH;
    localparam int TW  = `TID_WIDTH;
    localparam int IDV = `AXI_ID;

    logic             clk;
    logic             rst_n;
    logic [IW-1:0]    rid_i;
    logic [DW-1:0]    rdata_i;
    logic [1:0]       rresp_i;
    logic             rlast_i;
    logic             rvalid_i;
    logic             rready_o;
    logic             rmfifo_aempty_i;
    logic             rmfifo_rden_o;
    logic [TW+AW-1:0] rmfifo_data_i;
    logic             rspfifo_afull_i;
    logic             rspfifo_wren_o;
    logic [TW+2+DW-1:0] rspfifo_data_o;
    logic             fwfifo_afull_i;
    logic             fwfifo_wren_o;
    logic [AW+DW-1:0] fwfifo_data_o;
    logic             err_o;

    fill_r dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rid_i           (rid_i),
        .rdata_i         (rdata_i),
        .rresp_i         (rresp_i),
        .rlast_i         (rlast_i),
        .rvalid_i        (rvalid_i),
        .rready_o        (rready_o),
        .rmfifo_aempty_i (rmfifo_aempty_i),
        .rmfifo_rden_o   (rmfifo_rden_o),
        .rmfifo_data_i   (rmfifo_data_i),
        .rspfifo_afull_i (rspfifo_afull_i),
        .rspfifo_wren_o  (rspfifo_wren_o),
        .rspfifo_data_o  (rspfifo_data_o),
        .fwfifo_afull_i  (fwfifo_afull_i),
        .fwfifo_wren_o   (fwfifo_wren_o),
        .fwfifo_data_o   (fwfifo_data_o),
        .err_o           (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [DW-1:0] D_A5 = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam logic [DW-1:0] D_3C = 64'h3C3C_0000_1234_5678;
    localparam logic [DW-1:0] D_77 = 64'h7777_8888_9999_AAAA;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pops one RMiss entry and delivers its R beat; returns in S_PUSH.
    task automatic pop_accept(input logic [TW-1:0] tid, input logic [AW-1:0] addr,
                              input logic [DW-1:0] data, input logic [1:0] resp);
        rmfifo_data_i   = {tid, addr};
        rmfifo_aempty_i = 1'b0;
        #1;
        check("pop_rden", rmfifo_rden_o, 1'b1);
        tick;
        rmfifo_aempty_i = 1'b1;
        check("wait_rready", rready_o, 1'b1);
        rvalid_i = 1'b1;
        rdata_i  = data;
        rresp_i  = resp;
        tick;
        rvalid_i = 1'b0;
        rdata_i  = '0;
        rresp_i  = 2'b00;
    endtask

    initial begin
        int wr_cnt;
        rst_n           = 1'b0;
        rid_i           = IDV[IW-1:0];
        rdata_i         = '0;
        rresp_i         = 2'b00;
        rlast_i         = 1'b1;
        rvalid_i        = 1'b0;
        rmfifo_aempty_i = 1'b1;
        rmfifo_data_i   = '0;
        rspfifo_afull_i = 1'b0;
        fwfifo_afull_i  = 1'b0;

        // Reset: hold with a non-empty RMiss FIFO; nothing may fire.
        rmfifo_aempty_i = 1'b0;
        tick;
        check("rst_rden", rmfifo_rden_o, 1'b0);
        check("rst_rready", rready_o, 1'b0);
        check("rst_wren", {rspfifo_wren_o, fwfifo_wren_o}, 2'b00);
        rmfifo_aempty_i = 1'b1;
        tick;
        rst_n = 1'b1;
        tick;
        check("rst_rsp_data", rspfifo_data_o, '0);
        check("rst_fw_data", fwfifo_data_o, '0);
        check("rst_err", err_o, 1'b0);
        check("idle_rready", rready_o, 1'b0);

        // Normal OKAY transaction: pop, accept, push -> 3 cycles.
        pop_accept(4'd5, 32'h0000_1000, D_A5, 2'b00);
        check("ok_rready_push", rready_o, 1'b0);
        check("ok_wren", {rspfifo_wren_o, fwfifo_wren_o}, 2'b11);
        check("ok_rsp_data", rspfifo_data_o, {4'd5, 2'b00, D_A5});
        check("ok_fw_data", fwfifo_data_o, {32'h0000_1000, D_A5});
        tick;
        check("ok_done_wren", {rspfifo_wren_o, fwfifo_wren_o}, 2'b00);
        check("ok_done_rden", rmfifo_rden_o, 1'b0);

        // Error response: response push only, fill FIFO backpressure ignored.
        fwfifo_afull_i = 1'b1;
        pop_accept(4'd9, 32'h0000_2040, D_3C, 2'b10);
        check("err_wren", {rspfifo_wren_o, fwfifo_wren_o}, 2'b10);
        check("err_rsp_data", rspfifo_data_o, {4'd9, 2'b10, D_3C});
        tick;
        fwfifo_afull_i = 1'b0;
        check("err_done_wren", rspfifo_wren_o, 1'b0);
        check("err_o_default", err_o, 1'b0);

        // Backpressure: fill FIFO almost-full for 10 cycles with OKAY.
        fwfifo_afull_i = 1'b1;
        pop_accept(4'd2, 32'h0000_3000, D_77, 2'b00);
        wr_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (rspfifo_wren_o || fwfifo_wren_o || rready_o) wr_cnt++;
            if (i < 9) tick;
        end
        check("bp_hold_no_push", wr_cnt, 0);
        check("bp_rsp_data_stable", rspfifo_data_o, {4'd2, 2'b00, D_77});
        check("bp_fw_data_stable", fwfifo_data_o, {32'h0000_3000, D_77});
        tick;
        fwfifo_afull_i = 1'b0;
        #1;
        check("bp_release_wren", {rspfifo_wren_o, fwfifo_wren_o}, 2'b11);
        tick;
        check("bp_done_wren", rspfifo_wren_o, 1'b0);

        // Response FIFO almost-full also holds an error push.
        rspfifo_afull_i = 1'b1;
        pop_accept(4'd1, 32'h0000_0080, D_A5, 2'b11);
        tick;
        tick;
        check("rspbp_hold", rspfifo_wren_o, 1'b0);
        rspfifo_afull_i = 1'b0;
        #1;
        check("rspbp_release", {rspfifo_wren_o, fwfifo_wren_o}, 2'b10);
        tick;

        // Early rvalid in S_IDLE with empty RMiss FIFO: never accepted.
        rvalid_i = 1'b1;
        rdata_i  = D_3C;
        #1;
        check("early_rready", rready_o, 1'b0);
        wr_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (rready_o || rspfifo_wren_o || rmfifo_rden_o) wr_cnt++;
        end
        check("early_no_change", wr_cnt, 0);
        rvalid_i = 1'b0;
        rdata_i  = '0;

        // Reset while in S_WAIT: popped entry discarded, nothing pushed.
        rmfifo_data_i   = {4'd7, 32'h0000_5000};
        rmfifo_aempty_i = 1'b0;
        tick;
        rmfifo_aempty_i = 1'b1;
        rst_n    = 1'b0;
        rvalid_i = 1'b1;
        rdata_i  = D_77;
        #1;
        check("wrst_rready", rready_o, 1'b0);
        tick;
        rvalid_i = 1'b0;
        rst_n    = 1'b1;
        wr_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (rready_o || rspfifo_wren_o || fwfifo_wren_o) wr_cnt++;
        end
        check("wrst_no_push", wr_cnt, 0);
        check("wrst_rsp_cleared", rspfifo_data_o, '0);
        pop_accept(4'd6, 32'h0000_6000, D_3C, 2'b00);
        check("wrst_next_wren", {rspfifo_wren_o, fwfifo_wren_o}, 2'b11);
        check("wrst_next_fw", fwfifo_data_o, {32'h0000_6000, D_3C});
        tick;

`ifdef FILL_R_CHK_EN
        // Wrong RID: beat forced to SLVERR and err_o goes sticky.
        rid_i = IW'(IDV + 1);
        pop_accept(4'd5, 32'h0000_1000, D_A5, 2'b00);
        rid_i = IDV[IW-1:0];
        check("chk_err", err_o, 1'b1);
        check("chk_rsp", rspfifo_data_o, {4'd5, 2'b10, D_A5});
        check("chk_no_fill", fwfifo_wren_o, 1'b0);
        tick;
        pop_accept(4'd4, 32'h0000_1100, D_77, 2'b00);
        check("chk_sticky", err_o, 1'b1);
        check("chk_good_resp", rspfifo_data_o, {4'd4, 2'b00, D_77});
        tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        check("chk_err_reset", err_o, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
